// File: rtl/ultrasonic_scheduler_if.sv
// Register-read bus between the Nios and the ultrasonic scheduler.
// read_data is registered and follows addr by one cycle.
interface ultrasonic_scheduler_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic [31:0]       read_data;

  modport master (
    output addr,
    output rd,
    input  read_data
  );

  modport slave (
    input  addr,
    input  rd,
    output read_data
  );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Round-robin trigger/echo timer sharing one engine across N rangers.
// Define ULTRASONIC_IRQ_EN to add an irq output raised on each round wrap.
module ultrasonic_scheduler #(
  parameter int N_SENSORS      = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int GUARD_CYCLES   = 50000,
  parameter int ADDR_W         = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [N_SENSORS-1:0] i_echo,
  output logic [N_SENSORS-1:0] o_pulse,
  ultrasonic_scheduler_if.slave bus
`ifdef ULTRASONIC_IRQ_EN
  ,
  output logic                 o_irq
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_GUARD
  } state_t;

  localparam logic [30:0] TRIG_LAST  = 31'(TRIG_CYCLES - 1);
  localparam logic [30:0] TO_LIM     = 31'(TIMEOUT_CYCLES);
  localparam logic [30:0] GUARD_LAST = 31'(GUARD_CYCLES - 1);
  localparam logic [2:0]  IDX_LAST   = 3'(N_SENSORS - 1);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(N_SENSORS);

  state_t r_state;
  state_t w_state_nxt;
  logic [30:0] r_cnt;
  logic [30:0] w_cnt_nxt;
  logic [30:0] w_cnt_inc;
  logic [2:0]  r_idx;
  logic [7:0]  r_round;
  logic [N_SENSORS-1:0] r_valid;
  logic [31:0] r_res [N_SENSORS];
  logic [N_SENSORS-1:0] r_sync1;
  logic [N_SENSORS-1:0] r_sync2;
  logic [31:0] r_read_data;

  logic        w_echo;
  logic        w_store;
  logic [31:0] w_store_val;
  logic        w_adv;
  logic        w_round_inc;
  logic [31:0] w_status;
  logic [31:0] w_rd_val;

  assign w_cnt_inc   = r_cnt + 31'd1;
  assign w_round_inc = w_adv && (r_idx == IDX_LAST);

  always_comb begin
    w_echo  = 1'b0;
    o_pulse = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (r_idx == 3'(i)) begin
        w_echo     = r_sync2[i];
        o_pulse[i] = (r_state == S_TRIG);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_store     = 1'b0;
    w_store_val = '0;
    w_adv       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable) begin
          w_state_nxt = S_TRIG;
          w_cnt_nxt   = '0;
        end
      end
      S_TRIG: begin
        if (r_cnt == TRIG_LAST) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WAIT: begin
        if (w_echo) begin
          w_state_nxt = S_MEAS;
          w_cnt_nxt   = 31'd1;
        end else if (w_cnt_inc == TO_LIM) begin
          w_store     = 1'b1;
          w_store_val = {1'b1, 31'd0};
          w_state_nxt = S_GUARD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_MEAS: begin
        if (!w_echo) begin
          w_store     = 1'b1;
          w_store_val = {1'b0, r_cnt};
          w_state_nxt = S_GUARD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == TO_LIM) begin
          w_store     = 1'b1;
          w_store_val = {1'b1, TO_LIM};
          w_state_nxt = S_GUARD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_adv       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = i_enable ? S_TRIG : S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_status = {12'd0, r_idx, (r_state != S_IDLE),
                     r_round, 8'(r_valid)};

  // Result reads are write-first so a same-cycle store is not missed.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (bus.addr == ADDR_W'(i)) begin
        if (w_store && (r_idx == 3'(i)))
          w_rd_val = w_store_val;
        else
          w_rd_val = r_res[i];
      end
    end
    if (bus.addr == STAT_ADDR)
      w_rd_val = w_status;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_idx       <= '0;
      r_round     <= '0;
      r_valid     <= '0;
      r_read_data <= '0;
      for (int i = 0; i < N_SENSORS; i++)
        r_res[i] <= '0;
    end else begin
      r_sync1 <= i_echo;
      r_sync2 <= r_sync1;
      if (w_store) begin
        for (int i = 0; i < N_SENSORS; i++) begin
          if (r_idx == 3'(i)) begin
            r_res[i]   <= w_store_val;
            r_valid[i] <= 1'b1;
          end
        end
      end
      if (w_adv)
        r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      if (w_round_inc)
        r_round <= r_round + 8'd1;
      r_read_data <= w_rd_val;
    end
  end

  assign bus.read_data = r_read_data;

`ifdef ULTRASONIC_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_irq <= 1'b0;
    else if (w_round_inc)
      r_irq <= 1'b1;
    else if (bus.rd && (bus.addr == STAT_ADDR))
      r_irq <= 1'b0;
  end

  assign o_irq = r_irq;
`else
  logic w_unused_rd;
  assign w_unused_rd = bus.rd;
`endif

endmodule

// File: doc/ultrasonic_scheduler.md
Name: ultrasonic_scheduler

Overview:
Round-robin controller that shares one measurement engine across N_SENSORS ultrasonic rangers, so only one transducer is active at a time (no acoustic crosstalk).
- Per sensor: issues the trigger pulse, times the echo high-width in clk cycles, applies a timeout, then holds a guard gap.
- Stores one result word per sensor plus a status word, readable by the Nios through a register-read port.

Parameters:
N_SENSORS, 4, number of sensors sequenced (2..8)
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
TIMEOUT_CYCLES, 1900000, maximum cycles for echo-wait or echo-high (38 ms)
GUARD_CYCLES, 50000, idle gap after each measurement before the next trigger
ADDR_W, 4, read address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; 1 = run continuous rounds
addr  in  ADDR_W  register select
rd  in  1  read strobe (one cycle)
read_data  out  32  registered read data
echo  in  N_SENSORS  raw asynchronous echo lines
pulse  out  N_SENSORS  trigger outputs (at most one high)

Behaviour:
- Reset, taking effect on the next clk edge:
  - pulse=0, read_data=0.
  - All results=0, valid bits=0.
  - Sensor index=0, round counter=0, FSM=IDLE.
  - Reset asserted mid-operation aborts immediately; the same clearing applies.
- echo passes through a 2-flop synchronizer per bit. Only the synchronized bit of the current index is observed.
- FSM:
  - IDLE: if enable=1, go to TRIGGER and clear the cycle counter.
  - TRIGGER: pulse[idx]=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO with counter=0.
  - WAIT_ECHO: if sync echo=1, go to MEASURE with count=1. Otherwise the counter increments; on reaching TIMEOUT_CYCLES, store a timeout result and go to GUARD.
  - MEASURE: count increments while sync echo=1. When sync echo falls, store count and go to GUARD. If count reaches TIMEOUT_CYCLES while echo is still high, store a timeout result and go to GUARD.
  - GUARD: wait GUARD_CYCLES cycles, then advance idx with wrap N_SENSORS-1 -> 0.
    - Wrap 0 increments the round counter (8-bit, 255 -> 0).
    - Then go to TRIGGER if enable=1, else IDLE.
- Stored count equals the raw echo high-width in cycles; the synchronizer adds latency but not width error.
- Result word:
  - bit31 = timeout flag, bits30:0 = count.
  - Timeout result = bit31=1, count=TIMEOUT_CYCLES for a stuck-high echo, count=0 for no echo.
  - Storing sets valid[idx]; valid is sticky until reset.
- enable deasserted mid-measurement: the current sensor completes through GUARD, then the FSM parks in IDLE. idx is retained; resume continues from the next sensor.
- Echo already high on entry to WAIT_ECHO (sensor misbehaving): treated as a rising edge and measured.
- Register map, read_data valid one cycle after addr (independent of rd):
  - addr 0..N_SENSORS-1: result word.
  - addr N_SENSORS: status word.
    - bits[7:0] valid (upper bits 0).
    - bits[15:8] round counter.
    - bit16 busy (FSM != IDLE).
    - bits[19:17] current idx.
  - Other addresses read 0.
- Store and read of the same result in one cycle: read returns the newly stored value (write-first).

Optional Feature:
ULTRASONIC_IRQ_EN
- Defined:
  - Adds output port irq (1 bit, reset 0).
  - irq sets on the cycle the round counter increments.
  - irq clears on rd=1 with addr=N_SENSORS.
  - Simultaneous set and clear: set wins.
- Undefined: no irq port and no irq logic. rd is accepted but has no effect.

Test Plan:
Bench parameters for all scenarios: N_SENSORS=2, TRIG_CYCLES=4, TIMEOUT_CYCLES=100, GUARD_CYCLES=10.
- Basic measure: reset, enable=1; echo[0] high for 25 cycles starting 5 cycles after pulse[0] falls -> pulse[0] high exactly 4 cycles; read addr0 = 0x00000019; status valid=0b01.
- Round-robin: continue, echo[1] width 40 -> pulse[1] follows 10 guard cycles after sensor 0 completes; addr1=0x00000028; status round counter=1; pulse never two-hot.
- Timeouts: no echo on sensor 0 -> addr0=0x80000000 after 100 wait cycles; echo[1] held high -> addr1=0x80000064.
- Enable drop: deassert enable during MEASURE -> measurement stored, busy=0 after guard, no further pulse; re-enable -> next trigger on the following sensor index.
- Reset mid-TRIGGER: pulse=0 on the next edge; all reads return 0.
- With ULTRASONIC_IRQ_EN: irq=1 after round completes; rd of addr2 clears it; rd coincident with the round wrap leaves irq=1.
